mem_ctrl: RTL

- Memory controller sitting directly downstream of the load/store unit, and also serving instruction fetch.
- Accepts one data request (1/2/4 bytes, read or write) from the load/store unit and one instruction-word request from fetch.
- Serializes each request onto a single byte-wide synchronous RAM port with a 1-cycle read latency.
- Returns assembled little-endian words and signals completion, for both loads and stores, with a one-cycle done pulse.

---
 rtl/mem_ctrl_pkg.sv | 53 +++++
 rtl/mem_ctrl_if.sv | 33 +++
 rtl/mem_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared encodings for the byte-serial memory controller.
//   - state_t   : controller FSM states (also visible on the debug port)
//   - RW_* / LEN_*: request direction and length encodings of the LS unit
//   - len_bytes : byte count for an LSlen code (10 behaves like 11)
//   - byte_of / put_byte: little-endian byte lane select / insert
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA_RD = 2'd1,
        DATA_WR = 2'd2,
        INST_RD = 2'd3
    } state_t;

    localparam logic       RW_READ  = 1'b0;
    localparam logic       RW_WRITE = 1'b1;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b11;

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_BYTE: return 3'd1;
            LEN_HALF: return 3'd2;
            LEN_WORD: return 3'd4;
            default:  return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (idx)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: request/response bundle between the load/store unit plus
// instruction fetch (master) and the memory controller (slave).
//   Data side : dataEn is a one-cycle request pulse carrying LSRW/dataAddr/
//               LSlen/Sdata; completion is the one-cycle LOutEn pulse with
//               Ldata. LSfree is low while a data request is held or running.
//   Fetch side: instEn/instAddr are held until the one-cycle instOutEn pulse
//               that returns inst.
//   There is no backpressure on dataEn: the requester must only pulse it
//   while LSfree is high or in the LOutEn cycle; other pulses are dropped.
interface mem_ctrl_if;
    logic        dataEn;
    logic        LSRW;
    logic [31:0] dataAddr;
    logic [1:0]  LSlen;
    logic [31:0] Sdata;
    logic        LOutEn;
    logic [31:0] Ldata;
    logic        LSfree;
    logic        instEn;
    logic [31:0] instAddr;
    logic        instOutEn;
    logic [31:0] inst;

    modport master (
        output dataEn, LSRW, dataAddr, LSlen, Sdata, instEn, instAddr,
        input  LOutEn, Ldata, LSfree, instOutEn, inst
    );

    modport slave (
        input  dataEn, LSRW, dataAddr, LSlen, Sdata, instEn, instAddr,
        output LOutEn, Ldata, LSfree, instOutEn, inst
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises one data request (1/2/4 bytes, read or write) and
// instruction-word fetches onto a byte-wide synchronous RAM (1-cycle read
// latency), assembling little-endian words.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus (slave)     LS-unit and fetch request/response bundle
//   mem_a/mem_dout/mem_wr  registered RAM address, write byte, write strobe
//   mem_din         RAM read byte, valid the cycle after its address
//   dbg_state       current FSM state
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_ctrl_if.slave         bus,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_dout,
    output logic              mem_wr,
    input  logic [7:0]        mem_din,
    output state_t            dbg_state
);

    state_t      state;
    logic        busy;        // a data request is pending or in flight
    logic        accept;
    logic        busy_next;
    logic        pend_valid;
    logic        pend_rw;
    logic [31:0] pend_addr;
    logic [1:0]  pend_len;
    logic [31:0] pend_sdata;
    logic [31:0] base;        // start address of the running transfer
    logic [2:0]  nbytes;
    logic [2:0]  cnt;         // edges since the transfer started
    logic [31:0] asm_q;
    logic [31:0] asm_next;
    logic [ADDR_W-1:0] cur_a;

    // A request in the LOutEn cycle is accepted: the old one retires at that edge.
    assign accept    = bus.dataEn && (!busy || bus.LOutEn);
    assign busy_next = accept ? 1'b1 : (bus.LOutEn ? 1'b0 : busy);
    // Full 32-bit sum then truncation, so the address wraps past the top.
    assign cur_a     = ADDR_W'(base + 32'(cnt));
    // The byte addressed at count c arrives on mem_din at count c+2.
    assign asm_next  = put_byte(asm_q, 2'(cnt - 3'd2), mem_din);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            pend_valid    <= 1'b0;
            pend_rw       <= 1'b0;
            pend_addr     <= '0;
            pend_len      <= '0;
            pend_sdata    <= '0;
            base          <= '0;
            nbytes        <= '0;
            cnt           <= '0;
            asm_q         <= '0;
            mem_a         <= '0;
            mem_dout      <= '0;
            mem_wr        <= 1'b0;
            bus.LOutEn    <= 1'b0;
            bus.Ldata     <= '0;
            bus.LSfree    <= 1'b0;
            bus.instOutEn <= 1'b0;
            bus.inst      <= '0;
        end else begin
            busy          <= busy_next;
            bus.LSfree    <= !busy_next;
            bus.LOutEn    <= 1'b0;
            bus.instOutEn <= 1'b0;
            mem_wr        <= 1'b0;

            case (state)
                IDLE: begin
                    if (pend_valid) begin
                        pend_valid <= 1'b0;
                        base       <= pend_addr;
                        nbytes     <= len_bytes(pend_len);
                        cnt        <= 3'd1;
                        asm_q      <= '0;
                        mem_a      <= ADDR_W'(pend_addr);
                        if (pend_rw == RW_WRITE) begin
                            state    <= DATA_WR;
                            mem_dout <= byte_of(pend_sdata, 2'd0);
                            mem_wr   <= 1'b1;
                        end else begin
                            state <= DATA_RD;
                        end
                    // A data request arriving now outranks a waiting fetch;
                    // the instOutEn guard stops a repeat of the fetch just served.
                    end else if (!accept && bus.instEn && !bus.instOutEn) begin
                        state  <= INST_RD;
                        base   <= bus.instAddr;
                        nbytes <= 3'd4;
                        cnt    <= 3'd1;
                        asm_q  <= '0;
                        mem_a  <= ADDR_W'(bus.instAddr);
                    end
                end

                DATA_RD, INST_RD: begin
                    cnt <= cnt + 3'd1;
                    if (cnt < nbytes) begin
                        mem_a <= cur_a;
                    end
                    if (cnt >= 3'd2) begin
                        asm_q <= asm_next;
                    end
                    if (cnt == nbytes + 3'd1) begin
                        state <= IDLE;
                        if (state == DATA_RD) begin
                            bus.LOutEn <= 1'b1;
                            bus.Ldata  <= asm_next;
                        end else begin
                            bus.instOutEn <= 1'b1;
                            bus.inst      <= asm_next;
                        end
                    end
                end

                DATA_WR: begin
                    cnt <= cnt + 3'd1;
                    if (cnt < nbytes) begin
                        mem_a    <= cur_a;
                        mem_dout <= byte_of(pend_sdata, cnt[1:0]);
                        mem_wr   <= 1'b1;
                    end else begin
                        state      <= IDLE;
                        bus.LOutEn <= 1'b1;
                        bus.Ldata  <= '0;
                    end
                end

                default: state <= IDLE;
            endcase

            if (accept) begin
                pend_valid <= 1'b1;
                pend_rw    <= bus.LSRW;
                pend_addr  <= bus.dataAddr;
                pend_len   <= bus.LSlen;
                pend_sdata <= bus.Sdata;
            end
        end
    end

endmodule
